// File: rtl/sc_et_stream_ctrl.sv
// sc_et_stream_ctrl: sequencing controller for one stochastic-bitstream epoch.
// A bypass-masked counter steps once per accepted beat. Its value drives the
// external SNG comparator. The epoch ends on full-length overflow, on an early
// stop from the downstream accumulator, or on abort. The controller reports
// the beat count and the cause of termination.
module sc_et_stream_ctrl #(
  parameter int WIDTH    = 8,
  parameter int MIN_PREC = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [$clog2(WIDTH+1)-1:0]   prec,
  input  logic                         et_en,
  input  logic                         et_stop,
  input  logic                         abort,
  output logic                         busy,
  output logic                         sn_valid,
  input  logic                         sn_ready,
  output logic [WIDTH-1:0]             cnt,
  output logic [WIDTH-1:0]             bp,
  output logic                         last,
  output logic                         done,
  output logic [1:0]                   cause,
  output logic [WIDTH:0]               len
);

  localparam int PW = $clog2(WIDTH+1);

  localparam logic [1:0] C_NONE  = 2'd0;
  localparam logic [1:0] C_FULL  = 2'd1;
  localparam logic [1:0] C_EARLY = 2'd2;
  localparam logic [1:0] C_ABORT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_bp;
  logic [WIDTH:0]   r_len;
  logic [1:0]       r_cause;
  logic             r_et_en;

  logic [PW-1:0]    w_p;
  logic [WIDTH-1:0] w_bp_new;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_ovf;
  logic             w_run;
  logic             w_beat;
  logic             w_accept;
  logic             w_stop_early;

  // Clamp the requested precision into MIN_PREC..WIDTH.
  always_comb begin
    w_p = prec;
    if (prec < PW'(MIN_PREC)) begin
      w_p = PW'(MIN_PREC);
    end else if (prec > PW'(WIDTH)) begin
      w_p = PW'(WIDTH);
    end else begin
      w_p = prec;
    end
  end

  // Bypass mask: the low (WIDTH-p) bits are bypassed, the upper p bits count.
  always_comb begin
    w_bp_new = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bp_new[i] = ((i + int'(w_p)) < WIDTH);
    end
  end

  // Forcing the bypassed bits to 1 makes a plain +1 ripple straight into the
  // lowest active bit. This is the same carry chain as the bypass definition.
  // Masking the sum clears the bypassed bits again. The carry out is the
  // overflow, so the count wraps to 0 after the final value.
  assign w_g       = r_cnt | r_bp;
  assign w_sum     = {1'b0, w_g} + {{WIDTH{1'b0}}, 1'b1};
  assign w_cnt_nxt = w_sum[WIDTH-1:0] & ~r_bp;
  assign w_ovf     = w_sum[WIDTH];

  assign w_run        = (r_state == S_RUN);
  assign w_beat       = w_run & ~abort & sn_ready;
  assign w_accept     = (r_state == S_IDLE) & start & ~abort;
  assign w_stop_early = r_et_en & et_stop;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. Abort wins, then a full-length beat, then an early stop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (abort || (w_beat && (w_ovf || w_stop_early))) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Epoch datapath: latch the configuration on start, count beats in RUN,
  // record the cause, and clear the counter in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_bp    <= '0;
      r_len   <= '0;
      r_cause <= C_NONE;
      r_et_en <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_bp    <= w_bp_new;
            r_et_en <= et_en;
            r_cnt   <= '0;
            r_len   <= '0;
            r_cause <= C_NONE;
          end
        end
        S_RUN: begin
          if (abort) begin
            r_cause <= C_ABORT;
          end else if (w_beat) begin
            r_cnt <= w_cnt_nxt;
            r_len <= r_len + {{WIDTH{1'b0}}, 1'b1};
            if (w_ovf) begin
              r_cause <= C_FULL;
            end else if (w_stop_early) begin
              r_cause <= C_EARLY;
            end
          end
        end
        S_DONE: begin
          r_cnt <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign sn_valid = w_run & ~abort;
  assign cnt      = r_cnt;
  assign bp       = r_bp;
  assign last     = w_run & w_ovf;
  assign done     = (r_state == S_DONE);
  assign cause    = r_cause;
  assign len      = r_len;

endmodule

// File: tb/tb_sc_et_stream_ctrl.sv
// Directed, self-checking bench for sc_et_stream_ctrl (WIDTH=8, MIN_PREC=1).
// Each epoch pushes its expected count sequence to a queue. The queue is
// popped and compared whenever the DUT presents a beat.
module tb_sc_et_stream_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] prec;
  logic       et_en;
  logic       et_stop;
  logic       abort;
  logic       busy;
  logic       sn_valid;
  logic       sn_ready;
  logic [7:0] cnt;
  logic [7:0] bp;
  logic       last;
  logic       done;
  logic [1:0] cause;
  logic [8:0] len;

  int n_checks;
  int n_errors;
  int expq[$];

  sc_et_stream_ctrl #(.WIDTH(8), .MIN_PREC(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prec(prec), .et_en(et_en),
    .et_stop(et_stop), .abort(abort), .busy(busy), .sn_valid(sn_valid),
    .sn_ready(sn_ready), .cnt(cnt), .bp(bp), .last(last), .done(done),
    .cause(cause), .len(len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one epoch. Bit c of rdy_pat is sn_ready for RUN cycle c (1 after bit 31).
  // stop_beat (1-based, 0 = none) raises et_stop. abort_after (-1 = none) raises
  // abort in the RUN cycle after that many beats. noise holds start high and
  // disturbs prec/et_en once the epoch is running.
  task automatic run_epoch(input int prec_v, input bit et_en_v, input logic [31:0] rdy_pat,
                           input int stop_beat, input int abort_after, input bit noise,
                           input int exp_len, input int exp_cause);
    int p, step, n, beats, cyc;
    bit fin;
    logic [7:0] bpe;
    p = (prec_v < 1) ? 1 : ((prec_v > 8) ? 8 : prec_v);
    step = 1 << (8 - p);
    n = 1 << p;
    bpe = 8'((1 << (8 - p)) - 1);
    expq.delete();
    for (int k = 0; k < n; k++) expq.push_back(k * step);

    @(posedge clk); #1;
    start = 1'b1; prec = 4'(prec_v); et_en = et_en_v;
    et_stop = 1'b0; abort = 1'b0; sn_ready = 1'b0;
    @(posedge clk); #1;
    start = noise;
    if (noise) begin
      prec = 4'(8 - prec_v);
      et_en = ~et_en_v;
    end
    @(negedge clk);
    chk("load_busy", busy, 1'b1);
    chk("load_valid", sn_valid, 1'b0);
    chk("load_bp", bp, bpe);
    chk("load_cnt", cnt, 8'd0);

    beats = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 600 && expq.size() > 0) begin
      @(posedge clk); #1;
      sn_ready = (cyc < 32) ? rdy_pat[cyc] : 1'b1;
      abort    = (beats == abort_after);
      et_stop  = (stop_beat != 0) && (beats + 1 == stop_beat);
      @(negedge clk);
      chk("run_valid", sn_valid, !abort);
      chk("run_busy", busy, 1'b1);
      chk("run_done", done, 1'b0);
      chk("run_len", len, beats);
      chk("run_cnt", cnt, expq[0]);
      chk("run_last", last, (expq.size() == 1));
      if (abort) begin
        fin = 1'b1;
      end else if (sn_ready) begin
        if (expq.size() == 1 || (et_en_v && et_stop)) fin = 1'b1;
        void'(expq.pop_front());
        beats++;
      end
      cyc++;
    end
    if (!fin) chk("run_timeout", 1'b0, 1'b1);

    @(posedge clk); #1;
    abort = 1'b0; et_stop = 1'b0; sn_ready = 1'b1;
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b1);
    chk("done_valid", sn_valid, 1'b0);
    chk("done_bp", bp, bpe);

    @(posedge clk); #1;
    start = 1'b0; prec = 4'(prec_v); et_en = 1'b0;
    @(negedge clk);
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cnt", cnt, 8'd0);
    chk("idle_bp", bp, bpe);
    chk("idle_len", len, exp_len);
    chk("idle_cause", cause, exp_cause);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; start = 1'b0; prec = 4'd0; et_en = 1'b0;
    et_stop = 1'b0; abort = 1'b0; sn_ready = 1'b0;
    #3;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", sn_valid, 1'b0);
    chk("rst_cnt", cnt, 8'd0);
    chk("rst_bp", bp, 8'd0);
    chk("rst_len", len, 9'd0);
    chk("rst_cause", cause, 2'd0);
    chk("rst_last", last, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge clk); #1; rst_n = 1'b1;

    // start together with abort in IDLE is ignored
    @(posedge clk); #1; start = 1'b1; abort = 1'b1; prec = 4'd3;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_busy", busy, 1'b0);
    chk("start_abort_bp", bp, 8'd0);

    // full run, backpressure, early stop, ignored early stop
    run_epoch(3, 1'b0, 32'hFFFF_FFFF, 0, -1, 1'b0, 8, 1);
    run_epoch(2, 1'b0, 32'hFFFF_FF59, 0, -1, 1'b0, 4, 1);
    run_epoch(4, 1'b1, 32'hFFFF_FFFF, 5, -1, 1'b0, 5, 2);
    run_epoch(4, 1'b0, 32'hFFFF_FFFF, 5, -1, 1'b0, 16, 1);
    // abort after 3 beats, then FULL beating a coincident early stop
    run_epoch(4, 1'b1, 32'hFFFF_FFFF, 0, 3, 1'b0, 3, 3);
    run_epoch(1, 1'b1, 32'hFFFF_FFFF, 2, -1, 1'b0, 2, 1);
    // clamp at the bottom, max length with start/prec/et_en noise
    run_epoch(0, 1'b0, 32'hFFFF_FFFF, 0, -1, 1'b0, 2, 1);
    run_epoch(8, 1'b0, 32'hFFFF_FFFF, 0, -1, 1'b1, 256, 1);

    // reset during beat 3 of a prec=5 epoch
    @(posedge clk); #1; start = 1'b1; prec = 4'd5; sn_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_cnt", cnt, 8'd24);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", sn_valid, 1'b0);
    chk("mid_rst_cnt", cnt, 8'd0);
    chk("mid_rst_bp", bp, 8'd0);
    chk("mid_rst_len", len, 9'd0);
    chk("mid_rst_cause", cause, 2'd0);
    chk("mid_rst_last", last, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", done, 1'b0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_done", done, 1'b0);
    run_epoch(5, 1'b0, 32'hFFFF_FFFF, 0, -1, 1'b0, 32, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
